// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: drives pipeline register EN/CLR and PC write enable.
// Outputs are combinational from registered state and current hazard inputs; stall_cnt counts PC stalls.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic [4:0]       EX_WbRegNum,
  input  logic             EX_RegWrite,
  input  logic             EX_MemtoReg,
  input  logic             EX_MD,
  input  logic             EX_BranchTaken,
  input  logic             WB_SYSCALL,
  input  logic [31:0]      WB_v0,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IFID_CLR,
  output logic             IDEX_EN,
  output logic             IDEX_CLR,
  output logic             EXMEM_EN,
  output logic             EXMEM_CLR,
  output logic             MEMWB_EN,
  output logic             MEMWB_CLR,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MW = $clog2(MD_LAT) + 1;

  typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, halt_req, md_start, md_hold;

  always_comb begin
    load_use = EX_RegWrite && EX_MemtoReg && (EX_WbRegNum != 5'd0) &&
               ((ID_use_rs && (ID_rs == EX_WbRegNum)) ||
                (ID_use_rt && (ID_rt == EX_WbRegNum)));
    halt_req = WB_SYSCALL && (WB_v0 == 32'd10);
    md_start = (state_q == RUN) && EX_MD && (MD_LAT > 1);
    // The last busy cycle (md_cnt==1) lets the MD result into EX/MEM.
    md_hold  = ((state_q == MD_BUSY) && (md_cnt_q != MW'(1))) || md_start;
  end

  always_comb begin
    PC_EN     = 1'b1;
    IFID_EN   = 1'b1;
    IFID_CLR  = 1'b0;
    IDEX_EN   = 1'b1;
    IDEX_CLR  = 1'b0;
    EXMEM_EN  = 1'b1;
    EXMEM_CLR = 1'b0;
    MEMWB_EN  = 1'b1;
    MEMWB_CLR = 1'b0;
    halted    = 1'b0;
    if (!rst_n) begin
      PC_EN     = 1'b0;
      IFID_EN   = 1'b0;
      IDEX_EN   = 1'b0;
      EXMEM_EN  = 1'b0;
      MEMWB_EN  = 1'b0;
      IFID_CLR  = 1'b1;
      IDEX_CLR  = 1'b1;
      EXMEM_CLR = 1'b1;
      MEMWB_CLR = 1'b1;
    end else if (state_q == HALT) begin
      PC_EN    = 1'b0;
      IFID_EN  = 1'b0;
      IDEX_EN  = 1'b0;
      EXMEM_EN = 1'b0;
      MEMWB_EN = 1'b0;
      halted   = 1'b1;
    end else if (halt_req) begin
      // Default outputs so the SYSCALL itself retires.
    end else if (md_hold) begin
      PC_EN     = 1'b0;
      IFID_EN   = 1'b0;
      IDEX_EN   = 1'b0;
      EXMEM_CLR = 1'b1;
    end else if (state_q == MD_BUSY) begin
      // Final busy cycle: defaults.
    end else if (EX_BranchTaken) begin
      IFID_CLR = 1'b1;
      IDEX_CLR = 1'b1;
    end else if (load_use) begin
      PC_EN    = 1'b0;
      IFID_EN  = 1'b0;
      IDEX_CLR = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (state_q == HALT) begin
      state_d = HALT;
    end else if (halt_req) begin
      state_d  = HALT;
      md_cnt_d = '0;
    end else if (state_q == MD_BUSY) begin
      md_cnt_d = md_cnt_q - MW'(1);
      if (md_cnt_q == MW'(1)) state_d = RUN;
    end else if (md_start) begin
      state_d  = MD_BUSY;
      md_cnt_d = MW'(MD_LAT - 1);
    end
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALT) && !PC_EN) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch, MUL/DIV, SYSCALL halt, counter wrap.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs, ID_rt, EX_WbRegNum;
  logic        ID_use_rs, ID_use_rt, EX_RegWrite, EX_MemtoReg, EX_MD, EX_BranchTaken, WB_SYSCALL;
  logic [31:0] WB_v0;

  logic        PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR;
  logic        EXMEM_EN, EXMEM_CLR, MEMWB_EN, MEMWB_CLR, halted;
  logic [31:0] stall_cnt;

  logic        s_PC_EN, s_IFID_EN, s_IFID_CLR, s_IDEX_EN, s_IDEX_CLR;
  logic        s_EXMEM_EN, s_EXMEM_CLR, s_MEMWB_EN, s_MEMWB_CLR, s_halted;
  logic [3:0]  s_stall_cnt;

  logic [9:0]  ctl;
  assign ctl = {PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR,
                EXMEM_EN, EXMEM_CLR, MEMWB_EN, MEMWB_CLR, halted};

  localparam logic [9:0] C_RST  = 10'b0010101010;
  localparam logic [9:0] C_DEF  = 10'b1101010100;
  localparam logic [9:0] C_LU   = 10'b0001110100;
  localparam logic [9:0] C_BR   = 10'b1111110100;
  localparam logic [9:0] C_MD   = 10'b0000011100;
  localparam logic [9:0] C_HALT = 10'b0000000001;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .EX_WbRegNum(EX_WbRegNum),
    .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_MD(EX_MD),
    .EX_BranchTaken(EX_BranchTaken), .WB_SYSCALL(WB_SYSCALL), .WB_v0(WB_v0),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_CLR(IFID_CLR), .IDEX_EN(IDEX_EN),
    .IDEX_CLR(IDEX_CLR), .EXMEM_EN(EXMEM_EN), .EXMEM_CLR(EXMEM_CLR),
    .MEMWB_EN(MEMWB_EN), .MEMWB_CLR(MEMWB_CLR), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .EX_WbRegNum(EX_WbRegNum),
    .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_MD(EX_MD),
    .EX_BranchTaken(EX_BranchTaken), .WB_SYSCALL(WB_SYSCALL), .WB_v0(WB_v0),
    .PC_EN(s_PC_EN), .IFID_EN(s_IFID_EN), .IFID_CLR(s_IFID_CLR), .IDEX_EN(s_IDEX_EN),
    .IDEX_CLR(s_IDEX_CLR), .EXMEM_EN(s_EXMEM_EN), .EXMEM_CLR(s_EXMEM_CLR),
    .MEMWB_EN(s_MEMWB_EN), .MEMWB_CLR(s_MEMWB_CLR), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    EX_WbRegNum = 5'd0; EX_RegWrite = 1'b0; EX_MemtoReg = 1'b0;
    EX_MD = 1'b0; EX_BranchTaken = 1'b0; WB_SYSCALL = 1'b0; WB_v0 = 32'd0;
  endtask

  task automatic lw_hazard(input logic [4:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt);
    EX_RegWrite = 1'b1; EX_MemtoReg = 1'b1; EX_WbRegNum = wb;
    ID_rs = rs; ID_rt = rt; ID_use_rs = urs; ID_use_rt = urt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("reset_ctl%0d", i), 32'(ctl), 32'(C_RST));
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    #1 check("post_reset_ctl", 32'(ctl), 32'(C_DEF));
    check("post_reset_cnt", stall_cnt, 32'd0);

    lw_hazard(5'd8, 5'd8, 5'd3, 1'b1, 1'b1);
    #1 check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    tick(); idle();
    #1 check("lu_rs_cnt", stall_cnt, 32'd1);
    check("lu_one_cycle", 32'(ctl), 32'(C_DEF));

    lw_hazard(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1 check("lu_r0_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    lw_hazard(5'd9, 5'd1, 5'd9, 1'b1, 1'b1);
    #1 check("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    tick();
    lw_hazard(5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
    #1 check("lu_rt_unused_ctl", 32'(ctl), 32'(C_DEF));
    check("lu_cnt2", stall_cnt, 32'd2);
    tick();

    lw_hazard(5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
    EX_BranchTaken = 1'b1;
    #1 check("br_over_lu_ctl", 32'(ctl), 32'(C_BR));
    tick(); idle();
    #1 check("br_cnt", stall_cnt, 32'd2);

    EX_MD = 1'b1;
    #1 check("md_entry_ctl", 32'(ctl), 32'(C_MD));
    tick(); idle();
    #1 check("md_busy1_ctl", 32'(ctl), 32'(C_MD));
    lw_hazard(5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
    tick(); idle();
    #1 check("md_busy2_ctl", 32'(ctl), 32'(C_MD));
    tick();
    #1 check("md_final_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    #1 check("md_run_ctl", 32'(ctl), 32'(C_DEF));
    check("md_cnt", stall_cnt, 32'd5);

    EX_MD = 1'b1;
    tick(); idle();
    WB_SYSCALL = 1'b1; WB_v0 = 32'd10;
    #1 check("halt_entry_ctl", 32'(ctl), 32'(C_DEF));
    tick(); idle();
    #1 check("halt_ctl", 32'(ctl), 32'(C_HALT));
    check("halt_cnt", stall_cnt, 32'd6);
    lw_hazard(5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
    EX_MD = 1'b1;
    tick(); tick(); idle();
    #1 check("halt_sticky_ctl", 32'(ctl), 32'(C_HALT));
    check("halt_frozen_cnt", stall_cnt, 32'd6);

    rst_n = 1'b0;
    #1 check("rst_in_halt_ctl", 32'(ctl), 32'(C_RST));
    tick(); rst_n = 1'b1;
    #1 check("rst_exit_ctl", 32'(ctl), 32'(C_DEF));
    check("rst_exit_cnt", stall_cnt, 32'd0);

    WB_SYSCALL = 1'b1; WB_v0 = 32'd1;
    #1 check("sys_v0_1_ctl", 32'(ctl), 32'(C_DEF));
    tick(); idle();
    #1 check("sys_no_halt_ctl", 32'(ctl), 32'(C_DEF));

    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    lw_hazard(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
    repeat (17) tick();
    idle();
    #1 check("wrap_big_cnt", stall_cnt, 32'd17);
    check("wrap_small_cnt", 32'(s_stall_cnt), 32'd1);
    check("wrap_small_ctl", 32'({s_PC_EN, s_IFID_EN, s_IFID_CLR, s_IDEX_EN, s_IDEX_CLR,
                                 s_EXMEM_EN, s_EXMEM_CLR, s_MEMWB_EN, s_MEMWB_CLR, s_halted}),
          32'(C_DEF));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the EN/CLR pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Resolves load-use hazards, taken-branch flushes, multi-cycle MUL/DIV occupancy of EX, and SYSCALL halt.
- Holds a small state machine plus a stall performance counter.

Parameters:
- MD_LAT, 4, cycles a MUL/DIV occupies EX (>=1); EX is frozen for MD_LAT-1 extra cycles.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- ID_rs  in  5  source register A of instruction in ID
- ID_rt  in  5  source register B of instruction in ID
- ID_use_rs  in  1  ID instruction reads rs
- ID_use_rt  in  1  ID instruction reads rt
- EX_WbRegNum  in  5  destination register of instruction in EX
- EX_RegWrite  in  1  EX instruction writes a register
- EX_MemtoReg  in  1  EX instruction is a load
- EX_MD  in  1  EX instruction is MUL/DIV (valid first cycle in EX)
- EX_BranchTaken  in  1  EX resolved a taken branch/jump
- WB_SYSCALL  in  1  SYSCALL in WB
- WB_v0  in  32  current value of $v0 (forwarded)
- PC_EN  out  1  PC register write enable
- IFID_EN  out  1  IF/ID enable
- IFID_CLR  out  1  IF/ID clear
- IDEX_EN  out  1  ID/EX enable
- IDEX_CLR  out  1  ID/EX clear
- EXMEM_EN  out  1  EX/MEM enable
- EXMEM_CLR  out  1  EX/MEM clear
- MEMWB_EN  out  1  MEM/WB enable
- MEMWB_CLR  out  1  MEM/WB clear
- halted  out  1  pipeline halted by SYSCALL exit
- stall_cnt  out  CNT_W  cycles with PC_EN=0 while not halted

Behaviour:
- States: RUN, MD_BUSY, HALT. Registered state, busy counter md_cnt (width clog2(MD_LAT)+1), stall_cnt. Control outputs are combinational from the registered state and the current inputs; the pipeline registers sample them at the next posedge.
- Reset (rst_n=0 at posedge): state=RUN, md_cnt=0, stall_cnt=0. While rst_n=0, outputs are forced to: all *_CLR=1, all *_EN=0, PC_EN=0, halted=0. Reset mid-MD_BUSY or in HALT returns to RUN.
- Default RUN outputs: all EN=1, all CLR=0.
- Priority, highest first:
  1. HALT: all EN=0, all CLR=0, halted=1. Sticky until reset.
  2. Halt entry: in RUN or MD_BUSY, WB_SYSCALL=1 and WB_v0==10 -> next state HALT. The entry cycle itself keeps the default outputs so the SYSCALL retires. If WB_v0!=10, SYSCALL is ignored.
  3. MD_BUSY: PC_EN=0, IFID_EN=0, IDEX_EN=0, EXMEM_CLR=1, MEMWB_EN=1. Older instructions drain; bubbles enter MEM.
     - md_cnt decrements each cycle. When md_cnt==1, the next state is RUN.
     - The final busy cycle (md_cnt==1) uses default RUN outputs so the MD result is latched into EX/MEM.
  4. MD entry: in RUN, EX_MD=1 and MD_LAT>1 -> md_cnt=MD_LAT-1, next state MD_BUSY. The entry cycle uses MD_BUSY outputs. With MD_LAT=1, EX_MD has no effect.
  5. Branch flush: EX_BranchTaken=1 -> IFID_CLR=1, IDEX_CLR=1, PC_EN=1 (target loads). Overrides a load-use hazard in the same cycle.
  6. Load-use: EX_RegWrite & EX_MemtoReg & EX_WbRegNum!=0 & ((ID_use_rs & ID_rs==EX_WbRegNum) | (ID_use_rt & ID_rt==EX_WbRegNum)) -> PC_EN=0, IFID_EN=0, IDEX_CLR=1. Lasts exactly one cycle.
- A CLR asserted on a register takes precedence over its EN (register-side rule); the controller never needs EN=0 together with CLR=1 except during reset.
- EX_BranchTaken and EX_MD asserted together is illegal input; MD handling wins.
- stall_cnt increments (wrapping modulo 2^CNT_W) on each posedge with rst_n=1, state!=HALT, and PC_EN=0.

Test Plan:
- Reset held 3 cycles, then released -> during reset all CLR=1 and EN=0; first cycle after release all EN=1, CLR=0, stall_cnt=0.
- Load-use: EX lw $8 (WbRegNum=8, MemtoReg=1, RegWrite=1), ID rs=8, use_rs=1 -> one cycle PC_EN=0, IFID_EN=0, IDEX_CLR=1; stall_cnt=1. Same stimulus with WbRegNum=0 -> no stall.
- Load-use plus EX_BranchTaken=1 in the same cycle -> IFID_CLR=1, IDEX_CLR=1, PC_EN=1; stall_cnt unchanged.
- EX_MD pulse with MD_LAT=4 -> 3 cycles PC_EN=0 with EXMEM_CLR=1; 4th cycle default outputs; stall_cnt=3; state back to RUN.
- WB_SYSCALL=1, WB_v0=10 during MD_BUSY -> next cycle halted=1, all EN=0, stall_cnt frozen. Then rst_n=0 for 1 cycle -> RUN, halted=0. WB_v0=1 -> no halt.
- CNT_W=4, force 17 load-use stalls -> stall_cnt=1 (wraps).
